uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, baud_tick pulses per bit period.
REQ-002 Parameter: SYNC_STAGES, 2, rx synchronizer depth.
REQ-003 uart_ref_clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 baud_tick  input  1  one-cycle enable at OVERSAMPLE x baud, from the baud rate generator.
REQ-006 rx  input  1  asynchronous serial line, idle high.
REQ-007 data_bits_sel  input  2  00=5, 01=6, 10=7, 11=8 data bits.
REQ-008 parity_en  input  1  parity bit present.
REQ-009 parity_odd  input  1  1=odd parity, 0=even parity.
REQ-010 stop2  input  1  two stop bits expected.
REQ-011 rx_data  output  8  received character, LSB-aligned, unused upper bits zero.
REQ-012 rx_valid  output  1  rx_data and status valid.
REQ-013 rx_ready  input  1  consumer accepts the character.
REQ-014 parity_err  output  1  parity mismatch on the held character.
REQ-015 frame_err  output  1  stop bit sampled low on the held character.
REQ-016 break_det  output  1  held character is all-zero data with frame error.
REQ-017 overrun_err  output  1  one-cycle pulse: a completed character was dropped.

Function
REQ-018 rx shall pass through SYNC_STAGES flops; all decisions use the synchronized value.
REQ-019 The FSM shall have states IDLE, START, DATA, PARITY, STOP; the tick counter and bit counter advance only on baud_tick.
REQ-020 IDLE: on baud_tick with synced rx=0 -> START, tick counter cleared; data_bits_sel, parity_en, parity_odd and stop2 latched for the whole frame.
REQ-021 START: at tick count OVERSAMPLE/2-1 (mid-bit) the line is resampled; 1 -> IDLE (glitch rejected, nothing reported); 0 -> DATA, tick counter cleared.
REQ-022 DATA: sample every OVERSAMPLE ticks at mid-bit, shift LSB first; after 5+data_bits_sel bits -> PARITY if parity_en, else STOP.
REQ-023 PARITY: one mid-bit sample; mismatch against XOR of data (inverted when parity_odd) sets the frame's parity flag.
REQ-024 STOP: mid-bit sample per stop bit (two when stop2); any 0 sample sets the frame's framing flag; after the last stop sample -> IDLE, with no wait for end of bit, so a back-to-back start bit is detected.
REQ-025 Completion: on the cycle after the last stop sample, rx_data, parity_err, frame_err and break_det load and rx_valid asserts (1-cycle latency).
REQ-026 rx_valid and status shall hold stable until the cycle where rx_valid and rx_ready are both 1; rx_valid then deasserts unless a new completion occurs in the same cycle.
REQ-027 Completion while rx_valid=1 and rx_ready=0: new character discarded, held data unchanged, overrun_err pulses for one cycle.
REQ-028 Completion in the same cycle as a handshake: new character loads, rx_valid stays 1, no overrun.
REQ-029 Changes to configuration inputs mid-frame shall have no effect until the next start bit.

Reset
REQ-030 On rst_n=0: state IDLE, counters 0, synchronizer flops 1, rx_data 0, rx_valid, parity_err, frame_err, break_det and overrun_err 0.
REQ-031 Reset asserted mid-frame shall abort the frame with no output; after release, reception resumes only on a fresh falling edge seen in IDLE.

Structure
REQ-032 Package uart_pkg shall hold the rx state enum, the DATA_W=8 constant and the data_bits_sel encoding constants.
REQ-033 Sub-module uart_rx_sync shall implement the SYNC_STAGES synchronizer with reset value 1.

Verification
REQ-034 8N1, 0xA5 sent at 16 ticks/bit -> rx_data=0xA5, rx_valid=1, all errors 0; rx_ready=1 clears rx_valid next cycle.
REQ-035 7E1, 0x55 with wrong parity bit -> rx_data=0x55, parity_err=1; 5N2, 0x1F -> rx_data=0x1F.
REQ-036 rx low for 4 ticks only -> no rx_valid, FSM back in IDLE.
REQ-037 Line held low for 12 bit times (8N1) -> rx_data=0x00, frame_err=1, break_det=1.
REQ-038 Two back-to-back 8N1 frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, overrun_err pulses once; repeat with rx_ready=1 in the completion cycle -> 0x22 delivered, no overrun.
REQ-039 rst_n pulsed low during data bit 3 -> all outputs 0; the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   DATA_W          widest character the receiver holds
//   DATA_BITS_*     data_bits_sel encodings (5..8 data bits)
//   rx_state_e      receiver FSM states
//   last_data_idx() index of the final data bit for a data_bits_sel value
package uart_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] DATA_BITS_5 = 2'b00;
    localparam logic [1:0] DATA_BITS_6 = 2'b01;
    localparam logic [1:0] DATA_BITS_7 = 2'b10;
    localparam logic [1:0] DATA_BITS_8 = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    function automatic logic [2:0] last_data_idx(input logic [1:0] sel);
        logic [2:0] idx;
        unique case (sel)
            DATA_BITS_5: idx = 3'd4;
            DATA_BITS_6: idx = 3'd5;
            DATA_BITS_7: idx = 3'd6;
            default:     idx = 3'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
//   uart_ref_clk  receive clock
//   rst_n         asynchronous active-low reset; flops reset to 1 (line idle)
//   rx_async      raw serial input
//   rx_sync       synchronized serial line, SYNC_STAGES cycles of latency
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic uart_ref_clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge uart_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= rx_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rx_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with configurable framing and a valid/ready output.
//   uart_ref_clk, rst_n          clock, asynchronous active-low reset
//   baud_tick                    one-cycle enable at OVERSAMPLE x baud
//   rx                           asynchronous serial line, idle high
//   data_bits_sel, parity_en,    frame format, latched at each start bit
//   parity_odd, stop2
//   rx_data, rx_valid, rx_ready  held character and handshake
//   parity_err, frame_err,       status of the held character
//   break_det
//   overrun_err                  one-cycle pulse when a finished character is dropped
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              uart_ref_clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              rx,
    input  logic [1:0]        data_bits_sel,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det,
    output logic              overrun_err
);

    localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

    logic              rx_s;
    rx_state_e         state_q;
    logic [TickW-1:0]  tick_q;
    logic [2:0]        bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic [1:0]        bits_sel_q;
    logic              par_en_q;
    logic              par_odd_q;
    logic              stop2_q;
    logic              par_flag_q;
    logic              frm_flag_q;
    logic              done_q;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .uart_ref_clk(uart_ref_clk),
        .rst_n       (rst_n),
        .rx_async    (rx),
        .rx_sync     (rx_s)
    );

    // Frame FSM. After the start-bit midpoint every later sample lands one full
    // bit period on, i.e. at mid-bit.
    always_ff @(posedge uart_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            bits_sel_q <= DATA_BITS_8;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (baud_tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rx_s) begin
                            state_q    <= StStart;
                            tick_q     <= '0;
                            bit_q      <= '0;
                            shreg_q    <= '0;
                            par_flag_q <= 1'b0;
                            frm_flag_q <= 1'b0;
                            bits_sel_q <= data_bits_sel;
                            par_en_q   <= parity_en;
                            par_odd_q  <= parity_odd;
                            stop2_q    <= stop2;
                        end
                    end
                    StStart: begin
                        if (tick_q == TickMid) begin
                            tick_q  <= '0;
                            // A line back high at mid-bit was a glitch.
                            state_q <= rx_s ? StIdle : StData;
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    StData: begin
                        if (tick_q == TickLast) begin
                            tick_q         <= '0;
                            shreg_q[bit_q] <= rx_s;
                            if (bit_q == last_data_idx(bits_sel_q)) begin
                                bit_q   <= '0;
                                state_q <= par_en_q ? StParity : StStop;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    StParity: begin
                        if (tick_q == TickLast) begin
                            tick_q     <= '0;
                            // Unused upper shreg bits are zero, so a full XOR is safe.
                            par_flag_q <= rx_s != ((^shreg_q) ^ par_odd_q);
                            state_q    <= StStop;
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    StStop: begin
                        if (tick_q == TickLast) begin
                            tick_q <= '0;
                            if (!rx_s) begin
                                frm_flag_q <= 1'b1;
                            end
                            if (stop2_q && (bit_q == 3'd0)) begin
                                bit_q <= 3'd1;
                            end else begin
                                // Leave at mid stop bit so a back-to-back start is seen.
                                bit_q   <= '0;
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_q + TickW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Output holding register and handshake.
    always_ff @(posedge uart_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg_q;
                    rx_valid   <= 1'b1;
                    parity_err <= par_flag_q;
                    frame_err  <= frm_flag_q;
                    break_det  <= frm_flag_q && (shreg_q == '0);
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
